// File: rtl/leaf_arb_pkg.sv
// leaf_arb_pkg: shared definitions for the leaf user-channel arbiter.
//   PAYLOAD_BITS_DEF : default word width of the leaf_interface user channel
//   state_e          : arbiter FSM encoding (IDLE=0, GRANT=1)
//   clog2()          : ceiling log2, never less than 1 (usable in parameters)
package leaf_arb_pkg;

  localparam int PAYLOAD_BITS_DEF = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority picker.
//   req_i    : request vector, one bit per requester
//   rr_ptr_i : search start index (inclusive), always < NUM_REQ
//   any_o    : at least one request is set
//   idx_o    : first set index found searching upward from rr_ptr_i with wrap
module rr_pick
  import leaf_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int REQ_BITS = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [REQ_BITS-1:0] rr_ptr_i,
  output logic                any_o,
  output logic [REQ_BITS-1:0] idx_o
);

  // Walk offsets from farthest to nearest so the nearest hit is written last
  // and wins; avoids a break and keeps the loop a pure priority mux.
  always_comb begin
    int j;
    any_o = 1'b0;
    idx_o = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req_i[j]) begin
        any_o = 1'b1;
        idx_o = REQ_BITS'(j);
      end
    end
  end

endmodule

// File: rtl/leaf_user_arbiter.sv
// leaf_user_arbiter: shares one leaf_interface user input channel among
// NUM_REQ valid/ready word streams, round-robin, bursts of up to BURST_MAX.
//   clk, reset : clock, synchronous active-high reset
//   req_data   : packed requester words, requester i at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
//   req_valid  : per-requester valid
//   req_ready  : per-requester ready, at most one bit set (the granted one)
//   o_data     : registered output word (to i_user_data)
//   o_valid    : registered output valid (to i_user_valid)
//   i_ready    : downstream ready (from o_user_ready)
//   o_src      : requester index of the word in o_data
//   o_busy     : high while a grant is held
module leaf_user_arbiter
  import leaf_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int REQ_BITS     = clog2(NUM_REQ),
  parameter int PAYLOAD_BITS = PAYLOAD_BITS_DEF,
  parameter int BURST_MAX    = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [PAYLOAD_BITS-1:0]         o_data,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [REQ_BITS-1:0]             o_src,
  output logic                            o_busy
);

  localparam int CW = clog2(BURST_MAX + 1);

  state_e                  state_q, state_d;
  logic [REQ_BITS-1:0]     rr_ptr_q, rr_ptr_d;
  logic [REQ_BITS-1:0]     grant_q, grant_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;
  logic [REQ_BITS-1:0]     src_q, src_d;
  logic                    vld_q, vld_d;

  logic                    pick_any;
  logic [REQ_BITS-1:0]     pick_idx;
  logic                    space, gvalid, xfer, last;
  logic [PAYLOAD_BITS-1:0] gword;
  logic [REQ_BITS-1:0]     next_ptr;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .REQ_BITS(REQ_BITS)
  ) u_pick (
    .req_i   (req_valid),
    .rr_ptr_i(rr_ptr_q),
    .any_o   (pick_any),
    .idx_o   (pick_idx)
  );

  // Output register can take a word when empty or being drained this cycle.
  assign space    = !vld_q || i_ready;
  assign gvalid   = req_valid[grant_q];
  assign xfer     = (state_q == GRANT) && gvalid && space;
  assign last     = (cnt_q == CW'(BURST_MAX - 1));
  assign gword    = req_data[int'(grant_q)*PAYLOAD_BITS +: PAYLOAD_BITS];
  assign next_ptr = (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    src_d    = src_q;
    vld_d    = vld_q;
    // Drain happens in either state; a transfer below overrides it.
    if (vld_q && i_ready) vld_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          data_d = gword;
          src_d  = grant_q;
          vld_d  = 1'b1;
          cnt_d  = cnt_q + 1'b1;
        end
        // Release on a full burst or as soon as the granted stream goes idle,
        // regardless of backpressure.
        if ((xfer && last) || !gvalid) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      src_q    <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      src_q    <= src_d;
      vld_q    <= vld_d;
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == GRANT) req_ready[grant_q] = space;
  end

  assign o_data  = data_q;
  assign o_valid = vld_q;
  assign o_src   = src_q;
  assign o_busy  = (state_q == GRANT);

endmodule
